// File: rtl/mdu_controller.sv
// mdu_controller: iterative MIPS32 HI/LO multiply/divide sequencer; MDU_EARLY_TERM_EN enables early multiply exit
module mdu_controller #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_e,
  input  logic [1:0]       md_op_e,
  input  logic [WIDTH-1:0] src_a_e,
  input  logic [WIDTH-1:0] src_b_e,
  input  logic             mf_hilo_d,
  input  logic             mthi_e,
  input  logic             mtlo_e,
  input  logic [WIDTH-1:0] mt_data_e,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall_md,
  output logic             done,
  output logic             div0
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2;
  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               is_div, neg_res, neg_rem, dz, sa, sb, last;
  logic [WIDTH-1:0]   mag_a, mag_b, mq, rem, raw_a, abs_a, abs_b, quo, rmd;
  logic [2*WIDTH:0]   acc, sum;
  logic [WIDTH:0]     r_sh, diff;
  logic [2*WIDTH-1:0] prod, prod_s;
  always_comb begin
    sa = !md_op_e[0] && src_a_e[WIDTH-1];
    sb = !md_op_e[0] && src_b_e[WIDTH-1];
    abs_a = sa ? -src_a_e : src_a_e;
    abs_b = sb ? -src_b_e : src_b_e;
    sum = acc + (mq[0] ? {1'b0, mag_a, {WIDTH{1'b0}}} : '0);
    r_sh = {rem, mq[WIDTH-1]};
    diff = r_sh - {1'b0, mag_b};
`ifdef MDU_EARLY_TERM_EN
    // cnt holds the shifts skipped by an early exit; zero after a full run
    prod = acc[2*WIDTH-1:0] >> cnt;
    last = cnt == CW'(1) || (!is_div && mq[WIDTH-1:1] == '0);
`else
    prod = acc[2*WIDTH-1:0];
    last = cnt == CW'(1);
`endif
    prod_s = neg_res ? -prod : prod;
    quo = neg_res ? -mq : mq;
    rmd = neg_rem ? -rem : rem;
  end
  assign busy = state != IDLE;
  assign stall_md = busy && (mf_hilo_d || start_e || mthi_e || mtlo_e);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
      div0 <= 1'b0;
      is_div <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz <= 1'b0;
      mag_a <= '0;
      mag_b <= '0;
      raw_a <= '0;
      mq <= '0;
      rem <= '0;
      acc <= '0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      case (state)
        IDLE: begin
          if (start_e) begin
            mag_a <= abs_a;
            mag_b <= abs_b;
            raw_a <= src_a_e;
            neg_res <= sa ^ sb;
            neg_rem <= sa;
            is_div <= md_op_e[1];
            dz <= src_b_e == '0;
            mq <= md_op_e[1] ? abs_a : abs_b;
            rem <= '0;
            acc <= '0;
            cnt <= CW'(WIDTH);
            state <= CALC;
          end else begin
            if (mthi_e) hi <= mt_data_e;
            if (mtlo_e) lo <= mt_data_e;
          end
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (is_div) begin
            rem <= diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            mq <= {mq[WIDTH-2:0], ~diff[WIDTH]};
          end else begin
            acc <= sum >> 1;
            mq <= mq >> 1;
          end
          if (last) state <= FIX;
        end
        FIX: begin
          hi <= is_div ? (dz ? raw_a : rmd) : prod_s[2*WIDTH-1:WIDTH];
          lo <= is_div ? (dz ? '1 : quo) : prod_s[WIDTH-1:0];
          done <= 1'b1;
          div0 <= is_div && dz;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_controller.sv
// tb_mdu_controller: randomized and directed checks of mdu_controller against an arithmetic reference model
module tb_mdu_controller;
`ifdef MDU_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif
  logic clk = 0, rst = 1, start_e = 0, mf_hilo_d = 0, mthi_e = 0, mtlo_e = 0;
  logic [1:0] md_op_e = 0;
  logic [31:0] src_a_e = 0, src_b_e = 0, mt_data_e = 0;
  logic [31:0] hi, lo;
  logic busy, stall_md, done, div0;
  logic [31:0] m_hi = 0, m_lo = 0;
  int n_cmp = 0, n_err = 0;
  mdu_controller dut (
    .clk(clk), .rst(rst), .start_e(start_e), .md_op_e(md_op_e), .src_a_e(src_a_e),
    .src_b_e(src_b_e), .mf_hilo_d(mf_hilo_d), .mthi_e(mthi_e), .mtlo_e(mtlo_e),
    .mt_data_e(mt_data_e), .hi(hi), .lo(lo), .busy(busy), .stall_md(stall_md),
    .done(done), .div0(div0)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    la = op[0] ? longint'(a) : longint'($signed(a));
    lb = op[0] ? longint'(b) : longint'($signed(b));
    if (!op[1]) return la * lb;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction
  function automatic int exp_busy(input logic [1:0] op, input logic [31:0] b);
    logic [31:0] m;
    int n;
    m = (!op[0] && b[31]) ? -b : b;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return (ET && !op[1]) ? n + 1 : 33;
  endfunction
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic with_mt);
    logic [63:0] e;
    int nb, early;
    e = ref_op(op, a, b);
    @(negedge clk);
    start_e = 1; md_op_e = op; src_a_e = a; src_b_e = b;
    mthi_e = with_mt; mtlo_e = with_mt; mt_data_e = $urandom;
    @(negedge clk);
    start_e = 0; mthi_e = 0; mtlo_e = 0;
    check("hilo_hold", {hi, lo}, {m_hi, m_lo});
    nb = 0;
    early = 0;
    while (busy && nb < 100) begin
      nb++;
      if (done) early++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(nb), 64'(exp_busy(op, b)));
    check("done_early", 64'(early), 64'd0);
    check("result", {hi, lo}, e);
    check("done", 64'(done), 64'd1);
    check("div0", 64'(div0), 64'(op[1] && b == 0));
    m_hi = e[63:32];
    m_lo = e[31:0];
    @(negedge clk);
    check("done_pulse", {62'd0, done, div0}, 64'd0);
  endtask
  initial begin
    int nb;
    logic [31:0] b;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    check("rst_state", {hi, lo}, 64'd0);
    check("rst_flags", {61'd0, busy, done, div0}, 64'd0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
    check("plan_mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(2'b11, 32'd100, 32'd7, 1'b1);
    check("plan_divu", {hi, lo}, {32'd2, 32'd14});
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("plan_div", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("plan_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(2'b10, 32'h1234_5678, 32'd0, 1'b0);
    check("plan_div0", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    run_op(2'b01, 32'd3, 32'd5, 1'b0);
    check("plan_multu", {hi, lo}, 64'd15);
    run_op(2'b00, 32'd12345, 32'd0, 1'b0);
    @(negedge clk);
    mthi_e = 1; mt_data_e = 32'hCAFE_BABE;
    @(negedge clk);
    mthi_e = 0;
    check("mthi", 64'(hi), 64'hCAFE_BABE);
    mtlo_e = 1; mt_data_e = 32'h0BAD_F00D;
    @(negedge clk);
    mtlo_e = 0;
    check("mtlo", {hi, lo}, 64'hCAFE_BABE_0BAD_F00D);
    // MULTU in flight; MFHI/MFLO, a second MULT and a stray MTLO arrive meanwhile
    start_e = 1; md_op_e = 2'b01; src_a_e = 32'h1_0000; src_b_e = 32'h1_0000;
    @(negedge clk);
    start_e = 0;
    @(negedge clk);
    mf_hilo_d = 1; start_e = 1; md_op_e = 2'b00; src_a_e = 32'hFFFF_FFFD; src_b_e = 32'd7;
    mtlo_e = 1; mt_data_e = 32'h5555_5555;
    nb = 0;
    while (busy && nb < 100) begin
      #1;
      check("stall_busy", 64'(stall_md), 64'd1);
      @(negedge clk);
      mtlo_e = 0;
      nb++;
    end
    #1;
    check("stall_release", 64'(stall_md), 64'd0);
    check("mf_read", {hi, lo}, 64'h0000_0001_0000_0000);
    @(negedge clk);
    start_e = 0; mf_hilo_d = 0;
    check("held_start", 64'(busy), 64'd1);
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    check("held_result", {hi, lo}, ref_op(2'b00, 32'hFFFF_FFFD, 32'd7));
    m_hi = hi === 32'hFFFF_FFFF ? 32'hFFFF_FFFF : 32'hFFFF_FFFF;
    m_lo = 32'hFFFF_FFEB;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        3: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      run_op(2'($urandom_range(0, 3)), $urandom, b, 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    start_e = 1; md_op_e = 2'b10; src_a_e = 32'h7654_3210; src_b_e = 32'd3;
    @(negedge clk);
    start_e = 0;
    repeat (10) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_state", {hi, lo}, 64'd0);
    check("abort_flags", {61'd0, busy, done, div0}, 64'd0);
    repeat (3) @(negedge clk);
    check("abort_no_done", {62'd0, busy, done}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
